// File: rtl/fp_pkg.sv
// Shared fixed-point arithmetic types and helpers for the mul/div sequencer family.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINAL} fp_state_t;

  localparam int FP_WIDTH = 32;
  localparam int FP_FBITS = 24;

  // Widest operand fp_abs accepts; callers sign-extend narrower operands into it.
  localparam int FP_ABS_W = 64;

  function automatic logic [FP_ABS_W-1:0] fp_abs(input logic [FP_ABS_W-1:0] v);
    return v[FP_ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/fp_mul.sv
// Sequential signed Q-format multiplier: shift-add core, result WIDTH+2 edges after start, start ignored while busy.
// Optional FP_MUL_ROUND_EN rounds the magnitude half-away-from-zero instead of truncating.
module fp_mul
  import fp_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int FBITS = FP_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  fp_state_t         r_state;
  logic              r_sign;
  logic [AW-1:0]     r_mx_sh;
  logic [WIDTH-1:0]  r_my;
  logic [AW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic              r_ovf;
  logic [WIDTH-1:0]  r_p;

  logic [FP_ABS_W-1:0] w_x_ext;
  logic [FP_ABS_W-1:0] w_y_ext;
  logic [FP_ABS_W-1:0] w_x_abs;
  logic [FP_ABS_W-1:0] w_y_abs;
  logic [AW-1:0]       w_rnd;
  logic [AW-1:0]       w_m;
  logic [AW-1:0]       w_lim;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_m_lo;
  logic [WIDTH-1:0]    w_p;

  // |-2^(WIDTH-1)| still fits in WIDTH unsigned bits, so truncating the magnitude is safe.
  assign w_x_ext = FP_ABS_W'($signed(x));
  assign w_y_ext = FP_ABS_W'($signed(y));
  assign w_x_abs = fp_abs(w_x_ext);
  assign w_y_abs = fp_abs(w_y_ext);

`ifdef FP_MUL_ROUND_EN
  assign w_rnd = r_acc + (AW'(1) << (FBITS - 1));
`else
  assign w_rnd = r_acc;
`endif

  assign w_m    = w_rnd >> FBITS;
  // A negative result may reach -2^(WIDTH-1); a positive one stops one short.
  assign w_lim  = r_sign ? (AW'(1) << (WIDTH - 1)) : ((AW'(1) << (WIDTH - 1)) - AW'(1));
  assign w_ovf  = (w_m > w_lim);
  assign w_m_lo = w_m[WIDTH-1:0];
  assign w_p    = r_sign ? -w_m_lo : w_m_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_mx_sh <= '0;
      r_my    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_p     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign  <= x[WIDTH-1] ^ y[WIDTH-1];
            r_mx_sh <= AW'(w_x_abs[WIDTH-1:0]);
            r_my    <= w_y_abs[WIDTH-1:0];
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          // One extra pass at cnt==WIDTH keeps latency fixed at WIDTH+2.
          if (r_cnt == CW'(WIDTH)) begin
            r_state <= FINAL;
          end else begin
            if (r_my[0]) begin
              r_acc <= r_acc + r_mx_sh;
            end
            r_mx_sh <= r_mx_sh << 1;
            r_my    <= r_my >> 1;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        FINAL: begin
          if (w_ovf) begin
            r_ovf <= 1'b1;
            r_p   <= '0;
          end else begin
            r_valid <= 1'b1;
            r_p     <= w_p;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign ovf   = r_ovf;
  assign p     = r_p;

endmodule

// File: tb/tb_fp_mul.sv
// Testbench for fp_mul at Q8.24: directed vector table, handshake corner cases, random ops vs arithmetic model.
module tb_fp_mul;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        valid;
  logic        ovf;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] p;

  int checks = 0;
  int errors = 0;

  fp_mul #(.WIDTH(32), .FBITS(24)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .valid (valid),
    .ovf   (ovf),
    .x     (x),
    .y     (y),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        v;
    logic        o;
    logic [31:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then magnitude scaling and range test.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic v, output logic o, output logic [31:0] pp);
    longint      pr;
    logic [63:0] mag;
    logic [63:0] m;
    logic        s;
    pr  = longint'($signed(a)) * longint'($signed(b));
    mag = (pr < 0) ? 64'(-pr) : 64'(pr);
`ifdef FP_MUL_ROUND_EN
    mag = mag + 64'd8388608;
`endif
    m = mag / 64'd16777216;
    s = a[31] ^ b[31];
    o = s ? (m > 64'h80000000) : (m > 64'h7FFFFFFF);
    v = !o;
    if (o) pp = 32'h0;
    else   pp = s ? (32'h0 - m[31:0]) : m[31:0];
  endfunction

  // Waits (bounded) for a valid/ovf pulse; lat counts edges since the accepting edge.
  task automatic wait_done(input int lat0, output logic v, output logic o,
                           output logic [31:0] pp, output int lat);
    bit found;
    found = 0;
    lat = lat0;
    v = 0; o = 0; pp = 32'h0;
    for (int i = 0; i < 45 && !found; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid || ovf) begin
        found = 1;
        v = valid; o = ovf; pp = p;
      end
    end
    if (!found) lat = -1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic v,
                       output logic o, output logic [31:0] pp, output int lat);
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = $urandom; y = $urandom;
    wait_done(0, v, o, pp, lat);
  endtask

  task automatic quiet_window(input string name, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (valid || ovf) pulses++;
    end
    chk(name, 64'(pulses), 64'd0);
  endtask

  initial begin
    vec_t        tab [9];
    logic        v, o, ev, eo;
    logic [31:0] pp, ep;
    int          lat;

    tab[0] = '{32'h03000000, 32'h02000000, 1'b1, 1'b0, 32'h06000000};
    tab[1] = '{32'hFE800000, 32'h02000000, 1'b1, 1'b0, 32'hFD000000};
    tab[2] = '{32'h64000000, 32'h02000000, 1'b0, 1'b1, 32'h00000000};
    tab[3] = '{32'h80000000, 32'h01000000, 1'b1, 1'b0, 32'h80000000};
`ifdef FP_MUL_ROUND_EN
    tab[4] = '{32'h00000001, 32'hFF800000, 1'b1, 1'b0, 32'hFFFFFFFF};
`else
    tab[4] = '{32'h00000001, 32'hFF800000, 1'b1, 1'b0, 32'h00000000};
`endif
    tab[5] = '{32'h80000000, 32'hFF000000, 1'b0, 1'b1, 32'h00000000};
    tab[6] = '{32'h7FFFFFFF, 32'h01000000, 1'b1, 1'b0, 32'h7FFFFFFF};
    tab[7] = '{32'hFF000000, 32'hFF000000, 1'b1, 1'b0, 32'h01000000};
    tab[8] = '{32'h00000000, 32'hFE800000, 1'b1, 1'b0, 32'h00000000};

    rst = 1'b1; start = 1'b0; x = 32'h0; y = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_p", 64'(p), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(tab[i].x, tab[i].y, v, o, pp, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_valid", i), 64'(v), 64'(tab[i].v));
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(tab[i].o));
      chk($sformatf("vec%0d_p", i), 64'(pp), 64'(tab[i].p));
      chk($sformatf("vec%0d_busy_done", i), 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulse_len", i), 64'(valid | ovf), 64'd0);
      chk($sformatf("vec%0d_p_hold", i), 64'(p), 64'(tab[i].p));
    end

    // start pulsed at cycle 5 of a busy run must be ignored
    @(negedge clk);
    x = 32'h03000000; y = 32'h02000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    x = 32'h64000000; y = 32'h64000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, v, o, pp, lat);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_valid", 64'(v), 64'd1);
    chk("ign_p", 64'(pp), 64'h06000000);
    quiet_window("ign_no_second", 40);

    // start accepted in the same cycle valid is high
    do_op(32'h03000000, 32'h02000000, v, o, pp, lat);
    x = 32'hFE800000; y = 32'h02000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, v, o, pp, lat);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_valid", 64'(v), 64'd1);
    chk("b2b_p", 64'(pp), 64'hFD000000);

    // reset at cycle 10 aborts silently
    @(negedge clk);
    x = 32'h03000000; y = 32'h02000000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    quiet_window("abort_no_pulse", 40);
    do_op(32'h03000000, 32'h02000000, v, o, pp, lat);
    chk("abort_next_lat", 64'(lat), 64'd34);
    chk("abort_next_valid", 64'(v), 64'd1);
    chk("abort_next_p", 64'(pp), 64'h06000000);

    // random operands, scaled down often enough to exercise in-range products
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      a = $signed(a) >>> $urandom_range(0, 20);
      b = $signed(b) >>> $urandom_range(0, 20);
      model(a, b, ev, eo, ep);
      do_op(a, b, v, o, pp, lat);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd34);
      chk($sformatf("rnd%0d_flags", i), 64'({v, o}), 64'({ev, eo}));
      chk($sformatf("rnd%0d_p a=%h b=%h", i, a, b), 64'(pp), 64'(ep));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
